// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn sequencer.
//   cell_t       : encoding of one board cell (2 bits)
//   game_state_t : sequencer FSM states
//   WIN_LINES    : cell indices of the 8 winning lines, in line-index order
//                  (0-2 rows, 3-5 columns, 6 main diagonal, 7 anti diagonal)
//   NUM_CELLS    : number of board cells
//   NO_LINE      : win_line value meaning "no winning line"
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b01,
    O     = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    WAIT,
    CHECK,
    OVER
  } game_state_t;

  localparam int         NUM_CELLS = 9;
  localparam logic [3:0] NO_LINE   = 4'd15;

  localparam int WIN_LINES [8][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational win detector for a 3x3 tic-tac-toe board.
// Ports:
//   i_board [17:0] : cell i at [2i+1:2i] (00 empty, 01 X, 10 O)
//   i_sym   [1:0]  : symbol to test for (X or O)
//   o_hit          : 1 when i_sym owns a complete line
//   o_line  [3:0]  : lowest matching line index, NO_LINE when o_hit is 0
module ttt_win_detect
  import ttt_pkg::*;
(
  input  logic [17:0] i_board,
  input  logic [1:0]  i_sym,
  output logic        o_hit,
  output logic [3:0]  o_line
);

  always_comb begin
    o_hit  = 1'b0;
    o_line = NO_LINE;
    // Scan from the highest line down so the lowest matching index is the
    // one left standing.
    for (int l = 7; l >= 0; l--) begin
      if ((i_sym != EMPTY) &&
          (i_board[2*WIN_LINES[l][0] +: 2] == i_sym) &&
          (i_board[2*WIN_LINES[l][1] +: 2] == i_sym) &&
          (i_board[2*WIN_LINES[l][2] +: 2] == i_sym)) begin
        o_hit  = 1'b1;
        o_line = 4'(l);
      end
    end
  end

endmodule

// File: rtl/ttt_game_sequencer.sv
// Turn sequencer and referee for the VGA tic-tac-toe game.
// Accepts/rejects X and O move requests, holds the board, alternates turns
// and detects win and draw.
// Optional feature: define TURN_TIMEOUT_EN to enable the per-turn time limit
// (TIMEOUT_CYCLES clocks); without it the timeout output is tied low.
// Ports:
//   Clk            : system clock, all state on posedge
//   rst            : asynchronous active-low reset
//   new_game       : synchronous restart (same effect as reset)
//   position [3:0] : cursor cell 0..8 row-major, 9..15 invalid
//   playX / playO  : levels, rising edge requests an X / O move
//   board   [17:0] : cell i at [2i+1:2i], 00 empty, 01 X, 10 O
//   turn           : 0 = X to move, 1 = O to move
//   move_count[3:0]: accepted moves this game
//   move_reject    : 1-cycle pulse, request refused
//   game_over      : high once the game has ended
//   winner  [1:0]  : 00 none, 01 X, 10 O, 11 draw
//   win_line[3:0]  : winning line index, 15 = none
//   timeout        : 1-cycle pulse when a turn expires
module ttt_game_sequencer
  import ttt_pkg::*;
#(
  parameter int X_FIRST        = 1,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic        Clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic [3:0]  position,
  input  logic        playX,
  input  logic        playO,
  output logic [17:0] board,
  output logic        turn,
  output logic [3:0]  move_count,
  output logic        move_reject,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [3:0]  win_line,
  output logic        timeout
);

  localparam logic TURN_INIT = (X_FIRST != 0) ? 1'b0 : 1'b1;

  game_state_t r_state;
  logic [17:0] r_board;
  logic        r_turn;
  logic [3:0]  r_count;
  logic        r_reject;
  logic        r_over;
  logic [1:0]  r_winner;
  logic [3:0]  r_line;
  logic        r_px_s, r_px_h, r_po_s, r_po_h;

`ifdef TURN_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] r_tcnt;
  logic        r_timeout;
`endif

  logic       w_req_x, w_req_o, w_req_any;
  logic       w_accept;
  logic [1:0] w_sym;
  logic [1:0] w_cell;
  logic       w_hit;
  logic [3:0] w_line;

  assign w_req_x   = r_px_s & ~r_px_h;
  assign w_req_o   = r_po_s & ~r_po_h;
  assign w_req_any = w_req_x | w_req_o;

  // The mover's symbol follows turn; a request only gets in when its symbol
  // matches turn, so this is also the symbol written to the board.
  assign w_sym = r_turn ? O : X;

  always_comb begin
    w_cell = EMPTY;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (position == 4'(i)) w_cell = r_board[2*i +: 2];
    end
  end

  assign w_accept = (w_req_x ^ w_req_o) && (position <= 4'd8) &&
                    (w_cell == EMPTY) && (w_req_o == r_turn);

  ttt_win_detect u_win_detect (
    .i_board (r_board),
    .i_sym   (w_sym),
    .o_hit   (w_hit),
    .o_line  (w_line)
  );

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      r_state  <= WAIT;
      r_board  <= '0;
      r_turn   <= TURN_INIT;
      r_count  <= '0;
      r_reject <= 1'b0;
      r_over   <= 1'b0;
      r_winner <= 2'b00;
      r_line   <= NO_LINE;
      // History preset high: a play level held through reset is not an edge.
      r_px_s   <= 1'b1;
      r_px_h   <= 1'b1;
      r_po_s   <= 1'b1;
      r_po_h   <= 1'b1;
`ifdef TURN_TIMEOUT_EN
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
`endif
    end else if (new_game) begin
      r_state  <= WAIT;
      r_board  <= '0;
      r_turn   <= TURN_INIT;
      r_count  <= '0;
      r_reject <= 1'b0;
      r_over   <= 1'b0;
      r_winner <= 2'b00;
      r_line   <= NO_LINE;
      // Load current levels so a pending request is dropped, not replayed.
      r_px_s   <= playX;
      r_px_h   <= playX;
      r_po_s   <= playO;
      r_po_h   <= playO;
`ifdef TURN_TIMEOUT_EN
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_px_s   <= playX;
      r_px_h   <= r_px_s;
      r_po_s   <= playO;
      r_po_h   <= r_po_s;
      r_reject <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        WAIT: begin
          if (w_accept) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
              if (position == 4'(i)) r_board[2*i +: 2] <= w_sym;
            end
            r_count <= r_count + 4'd1;
            r_state <= CHECK;
`ifdef TURN_TIMEOUT_EN
            r_tcnt  <= '0;
`endif
          end else begin
            if (w_req_any) r_reject <= 1'b1;
`ifdef TURN_TIMEOUT_EN
            if (r_tcnt == TO_LAST) begin
              r_turn    <= ~r_turn;
              r_timeout <= 1'b1;
              r_tcnt    <= '0;
            end else begin
              r_tcnt <= r_tcnt + 32'd1;
            end
`endif
          end
        end
        CHECK: begin
          // Win is tested before the full-board case so a 9th-move win
          // reports the winner rather than a draw.
          if (w_hit) begin
            r_winner <= w_sym;
            r_line   <= w_line;
            r_over   <= 1'b1;
            r_state  <= OVER;
          end else if (r_count == 4'd9) begin
            r_winner <= 2'b11;
            r_over   <= 1'b1;
            r_state  <= OVER;
          end else begin
            r_turn  <= ~r_turn;
            r_state <= WAIT;
`ifdef TURN_TIMEOUT_EN
            r_tcnt  <= '0;
`endif
          end
        end
        OVER: begin
          if (w_req_any) r_reject <= 1'b1;
        end
        default: r_state <= WAIT;
      endcase
    end
  end

  assign board       = r_board;
  assign turn        = r_turn;
  assign move_count  = r_count;
  assign move_reject = r_reject;
  assign game_over   = r_over;
  assign winner      = r_winner;
  assign win_line    = r_line;

`ifdef TURN_TIMEOUT_EN
  assign timeout = r_timeout;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_ttt_game_sequencer.sv
module tb_ttt_game_sequencer;

  logic        Clk = 1'b0;
  logic        rst;
  logic        new_game;
  logic [3:0]  position;
  logic        playX;
  logic        playO;
  logic [17:0] board;
  logic        turn;
  logic [3:0]  move_count;
  logic        move_reject;
  logic        game_over;
  logic [1:0]  winner;
  logic [3:0]  win_line;
  logic        timeout;

  always #5 Clk = ~Clk;

  ttt_game_sequencer #(
    .X_FIRST        (1),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .Clk         (Clk),
    .rst         (rst),
    .new_game    (new_game),
    .position    (position),
    .playX       (playX),
    .playO       (playO),
    .board       (board),
    .turn        (turn),
    .move_count  (move_count),
    .move_reject (move_reject),
    .game_over   (game_over),
    .winner      (winner),
    .win_line    (win_line),
    .timeout     (timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          acc;
    logic [17:0] brd;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model of the game.
  logic [17:0] m_board;
  bit          m_turn;
  int          m_count;
  bit          m_over;
  logic [1:0]  m_winner;
  logic [3:0]  m_line;

  task automatic model_reset();
    m_board  = '0;
    m_turn   = 1'b0;
    m_count  = 0;
    m_over   = 1'b0;
    m_winner = 2'b00;
    m_line   = 4'd15;
  endtask

  function automatic bit three(input logic [17:0] b, input logic [1:0] s,
                               input int a, input int c, input int d);
    return (b[2*a +: 2] == s) && (b[2*c +: 2] == s) && (b[2*d +: 2] == s);
  endfunction

  function automatic logic [3:0] ref_line(input logic [17:0] b, input logic [1:0] s);
    logic [3:0] res;
    res = 4'd15;
    for (int r = 0; r < 3; r++)
      if (res == 4'd15 && three(b, s, 3*r, 3*r+1, 3*r+2)) res = 4'(r);
    for (int c = 0; c < 3; c++)
      if (res == 4'd15 && three(b, s, c, c+3, c+6)) res = 4'(3 + c);
    if (res == 4'd15 && three(b, s, 0, 4, 8)) res = 4'd6;
    if (res == 4'd15 && three(b, s, 2, 4, 6)) res = 4'd7;
    return res;
  endfunction

  // Drive one request, update the model, and push the expected outcome.
  task automatic play(input int pos, input bit is_o);
    logic [1:0] s;
    logic [3:0] ln;
    bit acc, old_turn, old_over;
    exp_t e;
    s = is_o ? 2'b10 : 2'b01;
    old_turn = m_turn;
    old_over = m_over;
    acc = 1'b0;
    if (!m_over && pos <= 8 && is_o == m_turn) acc = (m_board[2*pos +: 2] == 2'b00);
    if (acc) begin
      m_board[2*pos +: 2] = s;
      m_count++;
      ln = ref_line(m_board, s);
      if (ln != 4'd15) begin
        m_winner = s; m_line = ln; m_over = 1'b1;
      end else if (m_count == 9) begin
        m_winner = 2'b11; m_over = 1'b1;
      end else begin
        m_turn = ~m_turn;
      end
    end
    e.acc = acc; e.brd = m_board; e.cnt = 4'(m_count);
    sb.push_back(e);
    position = 4'(pos);
    if (is_o) playO = 1'b1; else playX = 1'b1;
    repeat (2) @(negedge Clk);
    chk("turn_n1", 32'(turn), 32'(old_turn));
    chk("over_n1", 32'(game_over), 32'(old_over));
    @(negedge Clk);
    chk("turn", 32'(turn), 32'(m_turn));
    chk("winner", 32'(winner), 32'(m_winner));
    chk("game_over", 32'(game_over), 32'(m_over));
    chk("win_line", 32'(win_line), 32'(m_line));
    playX = 1'b0; playO = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic play_both(input int pos);
    exp_t e;
    e.acc = 1'b0; e.brd = m_board; e.cnt = 4'(m_count);
    sb.push_back(e);
    position = 4'(pos);
    playX = 1'b1; playO = 1'b1;
    repeat (3) @(negedge Clk);
    chk("both_turn", 32'(turn), 32'(m_turn));
    playX = 1'b0; playO = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    @(negedge Clk);
    new_game = 1'b0;
    model_reset();
    chk("ng_board", 32'(board), 32'(m_board));
    chk("ng_count", 32'(move_count), 32'(m_count));
    chk("ng_over", 32'(game_over), 32'(m_over));
    chk("ng_winner", 32'(winner), 32'(m_winner));
    chk("ng_line", 32'(win_line), 32'(m_line));
    chk("ng_turn", 32'(turn), 32'(m_turn));
  endtask

  // Output monitor: any reject pulse or move_count step is a DUT outcome.
  logic [3:0] prev_cnt = 4'd0;
  bit         to_seen  = 1'b0;

  always @(negedge Clk) begin
    if (timeout) to_seen <= 1'b1;
    if (move_reject || (move_count != prev_cnt && move_count != 4'd0)) begin
      chk("sb_pending", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("accept", 32'(!move_reject), 32'(mon_e.acc));
        chk("board", 32'(board), 32'(mon_e.brd));
        chk("count", 32'(move_count), 32'(mon_e.cnt));
      end
    end
    prev_cnt <= move_count;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b0; new_game = 1'b0; playX = 1'b0; playO = 1'b0; position = 4'd0;
    model_reset();
    @(negedge Clk);
    chk("rst_board", 32'(board), 32'd0);
    chk("rst_turn", 32'(turn), 32'd0);
    chk("rst_count", 32'(move_count), 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);
    chk("rst_line", 32'(win_line), 32'd15);
    chk("rst_over", 32'(game_over), 32'd0);
    chk("rst_reject", 32'(move_reject), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge Clk);

    // Top-row win for X.
    play(0, 0); play(3, 1); play(1, 0); play(4, 1); play(2, 0);
    chk("t1_winner", 32'(winner), 32'd1);
    chk("t1_line", 32'(win_line), 32'd0);
    chk("t1_over", 32'(game_over), 32'd1);
    chk("t1_count", 32'(move_count), 32'd5);
    play(5, 1);

    // Occupied cell.
    pulse_new_game();
    play(4, 0);
    play(4, 1);
    chk("t2_cell4", 32'(board[9:8]), 32'd1);
    chk("t2_turn", 32'(turn), 32'd1);

`ifndef TURN_TIMEOUT_EN
    // Wrong symbol, invalid position, both edges at once.
    pulse_new_game();
    play(0, 1);
    play(9, 0);
    play_both(0);
    chk("t3_turn", 32'(turn), 32'd0);
    chk("t3_count", 32'(move_count), 32'd0);
`endif

    // Full board without a line.
    pulse_new_game();
    play(0, 0); play(1, 1); play(2, 0); play(4, 1); play(3, 0);
    play(5, 1); play(7, 0); play(6, 1); play(8, 0);
    chk("t4_winner", 32'(winner), 32'd3);
    chk("t4_line", 32'(win_line), 32'd15);
    chk("t4_count", 32'(move_count), 32'd9);

    // Asynchronous reset mid-game.
    pulse_new_game();
    play(0, 0); play(3, 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_board", 32'(board), 32'd0);
    chk("t5_async_turn", 32'(turn), 32'd0);
    chk("t5_async_count", 32'(move_count), 32'd0);
    @(negedge Clk);
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge Clk);

    // new_game in OVER, and new_game beating a pending request.
    play(0, 0); play(3, 1); play(1, 0); play(4, 1); play(2, 0);
    chk("t5_over", 32'(game_over), 32'd1);
    pulse_new_game();
    position = 4'd4;
    playX = 1'b1;
    @(negedge Clk);
    new_game = 1'b1;
    @(negedge Clk);
    new_game = 1'b0;
    chk("ng_prio_board", 32'(board), 32'd0);
    chk("ng_prio_reject", 32'(move_reject), 32'd0);
    repeat (2) @(negedge Clk);
    chk("ng_prio_count", 32'(move_count), 32'd0);
    playX = 1'b0;
    repeat (2) @(negedge Clk);

`ifdef TURN_TIMEOUT_EN
    new_game = 1'b1;
    @(negedge Clk);
    new_game = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge Clk);
      k++;
      if (timeout) break;
    end
    chk("to_cycles", 32'(k), 32'd8);
    chk("to_turn", 32'(turn), 32'd1);
    chk("to_board", 32'(board), 32'd0);
    chk("to_count", 32'(move_count), 32'd0);
`else
    k = 0;
    chk("to_never", 32'(to_seen), 32'd0);
    chk("to_now", 32'(timeout), 32'(k));
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
